// File: rtl/word_narrow_32_16.sv
// word_narrow_32_16: splits 32-bit words into 16-bit halfword beats.
// A word whose upper half is zero can be sent as a single beat, marked
// with out_ext, and each such beat is counted in skip_cnt.
//
// Handshake (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. A valid source holds its data stable and
// keeps valid high until that transfer. in_ready is combinational: when the
// last beat of a word completes, a new word can be accepted in the same
// cycle, so back-to-back words have no bubble between them.
module word_narrow_32_16 #(
    parameter bit SKIP_ZERO_HI = 1'b1,
    parameter bit HI_FIRST     = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             out_ext,
    input  logic             skip_clr,
    output logic [CNT_W-1:0] skip_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word;
    logic        cmp;
    logic        fire;
    logic        accept;

    // Compression is decided from the registered word, so it stays stable
    // for as long as the beat is stalled.
    assign cmp = SKIP_ZERO_HI && (word[31:16] == 16'h0000);

    // Beat outputs are a pure function of the state and the held word.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_last  = 1'b0;
        out_ext   = 1'b0;
        case (state)
            FIRST: begin
                out_valid = 1'b1;
                if (cmp) begin
                    out_data = word[15:0];
                    out_last = 1'b1;
                    out_ext  = 1'b1;
                end else begin
                    out_data = HI_FIRST ? word[31:16] : word[15:0];
                end
            end
            SECOND: begin
                out_valid = 1'b1;
                out_data  = HI_FIRST ? word[15:0] : word[31:16];
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fire     = out_valid & out_ready;
    assign in_ready = (state == IDLE) | (fire & out_last);
    assign accept   = in_valid & in_ready;

    // Next state: move only on a completed beat; a finished word is
    // immediately replaced by a newly accepted one if there is one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FIRST;
            end
            FIRST: begin
                if (fire) begin
                    if (!out_last) state_nxt = SECOND;
                    else           state_nxt = accept ? FIRST : IDLE;
                end
            end
            SECOND: begin
                if (fire) state_nxt = accept ? FIRST : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any half-sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Word register loads only on accept, so in_data is ignored otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      word <= 32'h0;
        else if (accept) word <= in_data;
    end

    // Compressed-word counter: clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            skip_cnt <= '0;
        else if (skip_clr)
            skip_cnt <= '0;
        else if (fire && out_ext && (skip_cnt != {CNT_W{1'b1}}))
            skip_cnt <= skip_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_word_narrow_32_16.sv
// Bench for word_narrow_32_16: directed scenarios plus a random phase on
// the default configuration, and short directed runs on a high-half-first
// instance and a 2-bit-counter instance.
module tb_word_narrow_32_16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ext;
  logic        skip_clr = 1'b0;
  logic [15:0] skip_cnt;

  word_narrow_32_16 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_ext(out_ext),
    .skip_clr(skip_clr), .skip_cnt(skip_cnt)
  );

  // ---------------- HI_FIRST=1, SKIP_ZERO_HI=0 instance ----------------
  logic        hf_in_valid = 1'b0;
  logic        hf_in_ready;
  logic [31:0] hf_in_data = 32'h0;
  logic        hf_out_valid;
  logic        hf_out_ready = 1'b1;
  logic [15:0] hf_out_data;
  logic        hf_out_last;
  logic        hf_out_ext;
  logic        hf_skip_clr = 1'b0;
  logic [15:0] hf_skip_cnt;

  word_narrow_32_16 #(.SKIP_ZERO_HI(1'b0), .HI_FIRST(1'b1), .CNT_W(16)) dut_hf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(hf_in_valid), .in_ready(hf_in_ready), .in_data(hf_in_data),
    .out_valid(hf_out_valid), .out_ready(hf_out_ready), .out_data(hf_out_data),
    .out_last(hf_out_last), .out_ext(hf_out_ext),
    .skip_clr(hf_skip_clr), .skip_cnt(hf_skip_cnt)
  );

  // ---------------- CNT_W=2 instance ----------------
  logic        c2_in_valid = 1'b0;
  logic        c2_in_ready;
  logic [31:0] c2_in_data = 32'h0;
  logic        c2_out_valid;
  logic        c2_out_ready = 1'b1;
  logic [15:0] c2_out_data;
  logic        c2_out_last;
  logic        c2_out_ext;
  logic        c2_skip_clr = 1'b0;
  logic [1:0]  c2_skip_cnt;

  word_narrow_32_16 #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_data(c2_in_data),
    .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_data(c2_out_data),
    .out_last(c2_out_last), .out_ext(c2_out_ext),
    .skip_clr(c2_skip_clr), .skip_cnt(c2_skip_cnt)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected beats packed as {data[15:0], last, ext}.
  localparam bit M_SKIP = 1'b1;
  localparam bit M_HI_FIRST = 1'b0;
  logic [17:0] exp_q[$];
  int unsigned skip_model = 0;

  function automatic void model_push(input logic [31:0] w);
    logic [15:0] lo, hi;
    lo = w[15:0];
    hi = w[31:16];
    if (M_SKIP && hi == 16'h0) begin
      exp_q.push_back({lo, 1'b1, 1'b1});
    end else if (M_HI_FIRST) begin
      exp_q.push_back({hi, 1'b0, 1'b0});
      exp_q.push_back({lo, 1'b1, 1'b0});
    end else begin
      exp_q.push_back({lo, 1'b0, 1'b0});
      exp_q.push_back({hi, 1'b1, 1'b0});
    end
  endfunction

  logic        held_v = 1'b0;
  logic [17:0] held_beat = '0;

  // Monitor: sampled mid-cycle, when the handshake inputs are stable.
  always @(negedge clk) begin
    logic [17:0] beat;
    logic [17:0] e;
    beat = {out_data, out_last, out_ext};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", {31'b0, out_valid}, 32'h1);
        check("stall_beat", {14'b0, beat}, {14'b0, held_beat});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {14'b0, beat}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {14'b0, beat}, {14'b0, e});
          if (e[0] && skip_model != 32'hFFFF) skip_model++;
        end
      end
      if (out_valid && !out_ready) check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      held_v = out_valid && !out_ready;
      held_beat = beat;
      if (in_valid && in_ready) model_push(in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and return just after the edge that accepts it.
  task automatic send(input logic [31:0] w);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("send_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] hi;
    hi = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
    return {hi, 16'($urandom)};
  endfunction

  // ---------------- directed and random steps ----------------
  initial begin
    logic acc;
    logic drained;

    // Reset state
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data", {16'b0, out_data}, 32'h0);
    check("rst_last_ext", {30'b0, out_last, out_ext}, 32'h0);
    check("rst_skip_cnt", {16'b0, skip_cnt}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'b0, in_ready}, 32'h1);

    // 1: normal word, low half first
    out_ready = 1'b1;
    send(32'h1234_5678);
    check("t1_beat0", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'h5678, 2'b00});
    tick();
    check("t1_beat1", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'h1234, 2'b10});
    tick();
    check("t1_idle", {31'b0, out_valid}, 32'h0);
    check("t1_skip_cnt", {16'b0, skip_cnt}, 32'h0);

    // 2: compressed word
    send(32'h0000_ABCD);
    check("t2_beat", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'hABCD, 2'b11});
    check("t2_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("t2_skip_cnt", {16'b0, skip_cnt}, 32'h1);
    check("t2_idle", {31'b0, out_valid}, 32'h0);

    // 3: backpressure
    out_ready = 1'b0;
    send(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_data", {16'b0, out_data}, 32'h0000_BEEF);
      check("t3_hold_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    check("t3_beat0", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'hBEEF, 2'b00});
    tick();
    check("t3_beat1", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'hDEAD, 2'b10});
    tick();
    check("t3_idle", {31'b0, out_valid}, 32'h0);

    // 4: back-to-back compressed words
    skip_clr = 1'b1;
    tick();
    skip_clr = 1'b0;
    skip_model = 0;
    check("t4_cleared", {16'b0, skip_cnt}, 32'h0);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      check("t4_in_ready", {31'b0, in_ready}, 32'h1);
      tick();
      check("t4_beat", {14'b0, out_data, out_last, out_ext}, {14'b0, 16'(i), 2'b11});
    end
    in_valid = 1'b0;
    in_data = 32'h0;
    tick();
    check("t4_skip_cnt", {16'b0, skip_cnt}, 32'h4);
    check("t4_idle", {31'b0, out_valid}, 32'h0);

    // 5: reset in the middle of a word
    send(32'h1111_2222);
    check("t5_beat0", {16'b0, out_data}, 32'h0000_2222);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    skip_model = 0;
    #1;
    check("t5_rst_valid", {31'b0, out_valid}, 32'h0);
    check("t5_rst_skip", {16'b0, skip_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    in_data = 32'hFFFF_1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_beat", {15'b0, out_valid, out_data}, 32'h0);
    end
    in_data = 32'h0;

    // 6a: high half first, no compression
    hf_in_valid = 1'b1;
    hf_in_data = 32'h0000_0001;
    check("t6_hf_in_ready", {31'b0, hf_in_ready}, 32'h1);
    tick();
    hf_in_valid = 1'b0;
    check("t6_hf_beat0", {13'b0, hf_out_valid, hf_out_data, hf_out_last, hf_out_ext}, {13'b0, 1'b1, 16'h0000, 2'b00});
    tick();
    check("t6_hf_beat1", {13'b0, hf_out_valid, hf_out_data, hf_out_last, hf_out_ext}, {13'b0, 1'b1, 16'h0001, 2'b10});
    tick();
    check("t6_hf_idle", {31'b0, hf_out_valid}, 32'h0);
    check("t6_hf_skip", {16'b0, hf_skip_cnt}, 32'h0);

    // 6b: 2-bit counter saturates
    c2_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c2_in_data = {16'h0, 16'($urandom)};
      tick();
    end
    c2_in_valid = 1'b0;
    tick();
    check("t6_c2_saturate", {30'b0, c2_skip_cnt}, 32'h3);
    // clear and increment in the same cycle: clear wins
    c2_in_valid = 1'b1;
    c2_in_data = 32'h0000_0055;
    tick();
    c2_skip_clr = 1'b1;
    tick();
    c2_in_valid = 1'b0;
    c2_skip_clr = 1'b0;
    check("t6_c2_clr_prio", {30'b0, c2_skip_cnt}, 32'h0);
    tick();
    check("t6_c2_after_clr", {30'b0, c2_skip_cnt}, 32'h1);

    // Random traffic with random backpressure on the default instance
    skip_clr = 1'b1;
    tick();
    skip_clr = 1'b0;
    skip_model = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data = rand_word();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      tick();
      drained = (exp_q.size() == 0) && !out_valid;
    end
    check("rand_drained", {31'b0, drained}, 32'h1);
    check("rand_skip_cnt", {16'b0, skip_cnt}, skip_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
